// File: rtl/fp_acc_fc.sv
// fp_acc_fc: streaming floating-point dot-product accumulator built around a single combinational adder.
module fp_adder2 #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10
) (
  input  logic [EXPONENT+MANTISSA:0] a,
  input  logic [EXPONENT+MANTISSA:0] b,
  output logic [EXPONENT+MANTISSA:0] y
);
  localparam int N = EXPONENT + MANTISSA + 1;
  localparam int EMAX = (1 << EXPONENT) - 1;
  localparam int W = MANTISSA + EMAX + 3;
  logic sa, sb, sr, a_big;
  logic [EXPONENT-1:0] ea, eb, emin, d;
  logic [W-1:0] xa, xb, r;
  logic [MANTISSA-1:0] frac;
  int lead, er;
  // The larger-exponent operand is shifted left instead of the smaller one right, so the sum is exact before truncation.
  always_comb begin
    sa = a[N-1];
    sb = b[N-1];
    ea = a[N-2 -: EXPONENT];
    eb = b[N-2 -: EXPONENT];
    a_big = ea >= eb;
    emin = a_big ? eb : ea;
    d = a_big ? ea - eb : eb - ea;
    xa = W'({1'b1, a[MANTISSA-1:0]}) << (a_big ? d : EXPONENT'(0));
    xb = W'({1'b1, b[MANTISSA-1:0]}) << (a_big ? EXPONENT'(0) : d);
    r = (sa == sb) ? xa + xb : (xa >= xb ? xa - xb : xb - xa);
    sr = (sa == sb || xa >= xb) ? sa : sb;
    lead = 0;
    for (int i = 0; i < W; i++) if (r[i]) lead = i;
    er = int'(emin) + lead - MANTISSA;
    frac = MANTISSA'((r << (W - 1 - lead)) >> (W - 1 - MANTISSA));
    y = (r == '0 || er <= 0) ? {sr, {(N-1){1'b0}}} :
        (er >= EMAX) ? {sr, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}} :
        {sr, EXPONENT'(er), frac};
  end
endmodule

module fp_acc_fc #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10,
  parameter int COUNT_W = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        prod_valid,
  output logic                        prod_ready,
  input  logic [EXPONENT+MANTISSA:0]  prod_data,
  input  logic                        prod_last,
  output logic                        acc_valid,
  input  logic                        acc_ready,
  output logic [EXPONENT+MANTISSA:0]  acc_data,
  output logic [COUNT_W-1:0]          acc_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic [EXPONENT+MANTISSA:0] sum, sum_nx, add_y;
  logic [COUNT_W-1:0] cnt, cnt_nx;
  logic take;
  fp_adder2 #(.EXPONENT(EXPONENT), .MANTISSA(MANTISSA)) u_add (.a(sum), .b(prod_data), .y(add_y));
  assign prod_ready = state != HOLD;
  assign take = prod_valid && prod_ready;
  assign acc_valid = state == HOLD;
  assign acc_data = acc_valid ? sum : '0;
  assign acc_count = acc_valid ? cnt : '0;
  // The first beat of a dot-product loads the sum directly, since the adder cannot represent a true zero.
  always_comb begin
    state_nx = state;
    sum_nx = sum;
    cnt_nx = cnt;
    case (state)
      IDLE: if (take) begin
        sum_nx = prod_data;
        cnt_nx = COUNT_W'(1);
        state_nx = prod_last ? HOLD : ACCUM;
      end
      ACCUM: if (take) begin
        sum_nx = add_y;
        cnt_nx = &cnt ? cnt : cnt + COUNT_W'(1);
        state_nx = prod_last ? HOLD : ACCUM;
      end
      HOLD: state_nx = acc_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sum <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      sum <= sum_nx;
      cnt <= cnt_nx;
    end
  end
endmodule
